// File: rtl/imem_read_arbiter.sv
// Two-requester AXI4-Lite read arbiter for the instruction memory: round-robin grant,
// one outstanding transaction, watchdog that answers DECERR when the slave stalls.
module imem_read_arbiter #(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int TO_WIDTH       = 9
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic [31:0] S0_AXI_ARADDR,
    input  logic [2:0]  S0_AXI_ARPROT,
    input  logic        S0_AXI_ARVALID,
    output logic        S0_AXI_ARREADY,
    output logic [31:0] S0_AXI_RDATA,
    output logic [1:0]  S0_AXI_RRESP,
    output logic        S0_AXI_RVALID,
    input  logic        S0_AXI_RREADY,

    input  logic [31:0] S1_AXI_ARADDR,
    input  logic [2:0]  S1_AXI_ARPROT,
    input  logic        S1_AXI_ARVALID,
    output logic        S1_AXI_ARREADY,
    output logic [31:0] S1_AXI_RDATA,
    output logic [1:0]  S1_AXI_RRESP,
    output logic        S1_AXI_RVALID,
    input  logic        S1_AXI_RREADY,

    output logic [31:0] M_AXI_ARADDR,
    output logic [2:0]  M_AXI_ARPROT,
    output logic        M_AXI_ARVALID,
    input  logic        M_AXI_ARREADY,
    input  logic [31:0] M_AXI_RDATA,
    input  logic [1:0]  M_AXI_RRESP,
    input  logic        M_AXI_RVALID,
    output logic        M_AXI_RREADY,

    output logic        grant_id,
    output logic        busy,
    output logic        err_timeout
);

    typedef enum logic [1:0] {IDLE, ADDR, RWAIT, RESP} state_t;

    // Firing one count early makes the DECERR visible TIMEOUT_CYCLES-1 cycles after ADDR entry.
    localparam logic [TO_WIDTH-1:0] WD_FIRE = TO_WIDTH'(TIMEOUT_CYCLES - 2);
    localparam logic [TO_WIDTH-1:0] WD_MAX  = {TO_WIDTH{1'b1}};
    localparam logic [1:0]          DECERR  = 2'b11;

    state_t              state;
    logic                last_grant;
    logic [TO_WIDTH-1:0] wd;

    logic                pick_valid;
    logic                pick_id;
    logic [31:0]         pick_addr;
    logic [2:0]          pick_prot;
    logic                ar_hs;
    logic                r_hs;
    logic                resp_hs;

    function automatic logic [TO_WIDTH-1:0] wd_inc(input logic [TO_WIDTH-1:0] v);
        return (v == WD_MAX) ? v : v + TO_WIDTH'(1);
    endfunction

    always_comb begin
        pick_valid = S0_AXI_ARVALID | S1_AXI_ARVALID;
        pick_id    = (S0_AXI_ARVALID && S1_AXI_ARVALID) ? ~last_grant : S1_AXI_ARVALID;
        pick_addr  = pick_id ? S1_AXI_ARADDR : S0_AXI_ARADDR;
        pick_prot  = pick_id ? S1_AXI_ARPROT : S0_AXI_ARPROT;
        ar_hs      = M_AXI_ARVALID && M_AXI_ARREADY;
        r_hs       = M_AXI_RVALID && M_AXI_RREADY;
        resp_hs    = grant_id ? (S1_AXI_RVALID && S1_AXI_RREADY)
                              : (S0_AXI_RVALID && S0_AXI_RREADY);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            last_grant     <= 1'b1;
            wd             <= '0;
            grant_id       <= 1'b0;
            busy           <= 1'b0;
            err_timeout    <= 1'b0;
            M_AXI_ARADDR   <= '0;
            M_AXI_ARPROT   <= '0;
            M_AXI_ARVALID  <= 1'b0;
            M_AXI_RREADY   <= 1'b0;
            S0_AXI_ARREADY <= 1'b0;
            S0_AXI_RDATA   <= '0;
            S0_AXI_RRESP   <= '0;
            S0_AXI_RVALID  <= 1'b0;
            S1_AXI_ARREADY <= 1'b0;
            S1_AXI_RDATA   <= '0;
            S1_AXI_RRESP   <= '0;
            S1_AXI_RVALID  <= 1'b0;
        end else begin
            S0_AXI_ARREADY <= 1'b0;
            S1_AXI_ARREADY <= 1'b0;
            err_timeout    <= 1'b0;

            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        M_AXI_ARADDR   <= pick_addr;
                        M_AXI_ARPROT   <= pick_prot;
                        M_AXI_ARVALID  <= 1'b1;
                        S0_AXI_ARREADY <= ~pick_id;
                        S1_AXI_ARREADY <= pick_id;
                        grant_id       <= pick_id;
                        busy           <= 1'b1;
                        wd             <= '0;
                        state          <= ADDR;
                    end
                end

                ADDR, RWAIT: begin
                    if (state == ADDR && ar_hs) begin
                        M_AXI_ARVALID <= 1'b0;
                        M_AXI_RREADY  <= 1'b1;
                        wd            <= wd_inc(wd);
                        state         <= RWAIT;
                    end else if (state == RWAIT && r_hs) begin
                        M_AXI_RREADY <= 1'b0;
                        if (grant_id) begin
                            S1_AXI_RDATA  <= M_AXI_RDATA;
                            S1_AXI_RRESP  <= M_AXI_RRESP;
                            S1_AXI_RVALID <= 1'b1;
                        end else begin
                            S0_AXI_RDATA  <= M_AXI_RDATA;
                            S0_AXI_RRESP  <= M_AXI_RRESP;
                            S0_AXI_RVALID <= 1'b1;
                        end
                        state <= RESP;
                    end else if (wd == WD_FIRE) begin
                        // Abandon the slave: any late beat is never accepted.
                        M_AXI_ARVALID <= 1'b0;
                        M_AXI_RREADY  <= 1'b0;
                        err_timeout   <= 1'b1;
                        if (grant_id) begin
                            S1_AXI_RDATA  <= '0;
                            S1_AXI_RRESP  <= DECERR;
                            S1_AXI_RVALID <= 1'b1;
                        end else begin
                            S0_AXI_RDATA  <= '0;
                            S0_AXI_RRESP  <= DECERR;
                            S0_AXI_RVALID <= 1'b1;
                        end
                        state <= RESP;
                    end else begin
                        wd <= wd_inc(wd);
                    end
                end

                RESP: begin
                    if (resp_hs) begin
                        S0_AXI_RVALID <= 1'b0;
                        S1_AXI_RVALID <= 1'b0;
                        last_grant    <= grant_id;
                        busy          <= 1'b0;
                        state         <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_read_arbiter.sv
// Randomized bench for imem_read_arbiter: a behavioural slave plus a round-robin / timing
// reference model derived from the arbiter's transaction rules.
module tb_imem_read_arbiter;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] araddr [2];
    logic [2:0]  arprot [2];
    logic [1:0]  arvalid = '0;
    logic [1:0]  arready;
    logic [31:0] rdata [2];
    logic [1:0]  rresp [2];
    logic [1:0]  rvalid;
    logic [1:0]  rready = '0;
    logic [31:0] m_araddr;
    logic [2:0]  m_arprot;
    logic        m_arvalid;
    logic        m_arready = 1'b0;
    logic [31:0] m_rdata = '0;
    logic [1:0]  m_rresp = '0;
    logic        m_rvalid = 1'b0;
    logic        m_rready;
    logic        grant_id, busy, err_timeout;

    imem_read_arbiter #(.TIMEOUT_CYCLES(TO), .TO_WIDTH(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .S0_AXI_ARADDR(araddr[0]), .S0_AXI_ARPROT(arprot[0]), .S0_AXI_ARVALID(arvalid[0]),
        .S0_AXI_ARREADY(arready[0]), .S0_AXI_RDATA(rdata[0]), .S0_AXI_RRESP(rresp[0]),
        .S0_AXI_RVALID(rvalid[0]), .S0_AXI_RREADY(rready[0]),
        .S1_AXI_ARADDR(araddr[1]), .S1_AXI_ARPROT(arprot[1]), .S1_AXI_ARVALID(arvalid[1]),
        .S1_AXI_ARREADY(arready[1]), .S1_AXI_RDATA(rdata[1]), .S1_AXI_RRESP(rresp[1]),
        .S1_AXI_RVALID(rvalid[1]), .S1_AXI_RREADY(rready[1]),
        .M_AXI_ARADDR(m_araddr), .M_AXI_ARPROT(m_arprot), .M_AXI_ARVALID(m_arvalid),
        .M_AXI_ARREADY(m_arready), .M_AXI_RDATA(m_rdata), .M_AXI_RRESP(m_rresp),
        .M_AXI_RVALID(m_rvalid), .M_AXI_RREADY(m_rready),
        .grant_id(grant_id), .busy(busy), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // Instruction memory contents seen by the slave.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h10) return 32'h0050_0093;
        return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
    endfunction

    // Behavioural slave, driven on the falling edge.
    int          ar_lat = 0, r_lat = 0, ar_cnt = 0, r_cnt = 0;
    bit          hang_ar = 0, hang_r = 0, r_pend = 0, rr_last = 0;
    logic [1:0]  slv_resp = 2'b00;
    logic [31:0] r_addr = '0;
    logic [31:0] seen_addr [$];
    logic [2:0]  seen_prot [$];

    always @(negedge clk) begin
        if (!rst_n) begin
            m_arready = 0; m_rvalid = 0; m_rdata = '0; m_rresp = '0;
            r_pend = 0; ar_cnt = 0; r_cnt = 0; rr_last = 0;
        end else begin
            if (m_arvalid && !m_arready && !hang_ar) begin
                if (ar_cnt >= ar_lat) begin
                    m_arready = 1;
                    seen_addr.push_back(m_araddr);
                    seen_prot.push_back(m_arprot);
                    r_addr = m_araddr; r_pend = 1; r_cnt = 0;
                end else ar_cnt++;
            end else begin
                m_arready = 0; ar_cnt = 0;
            end
            if (m_rvalid) begin
                if (rr_last) begin m_rvalid = 0; r_pend = 0; end
            end else if (r_pend && m_rready && !hang_r) begin
                if (r_cnt >= r_lat) begin
                    m_rvalid = 1; m_rdata = mem_word(r_addr); m_rresp = slv_resp;
                end else r_cnt++;
            end
            rr_last = m_rready;
        end
    end

    // Observations of one run, indexed by requester.
    int          g_cyc [2], d_cyc [2], rv_cyc [2];
    logic [31:0] got_data [2];
    logic [1:0]  got_resp [2];
    int          gid_q [$];
    logic        gout_q [$];
    int          unstable, stray, err_cyc, err_cnt;
    logic        marv_at_err, mrr_at_err;
    bit          run_to;

    task automatic run_reqs(input logic [1:0] go, input logic [31:0] a0, input logic [31:0] a1,
                            input int rdly);
        bit got [2];
        bit done [2];
        int rc [2];
        int cyc = 0;
        gid_q.delete(); gout_q.delete(); seen_addr.delete(); seen_prot.delete();
        unstable = 0; stray = 0; err_cyc = -1; err_cnt = 0; marv_at_err = 0; mrr_at_err = 0;
        araddr[0] = a0; araddr[1] = a1;
        arprot[0] = 3'($urandom); arprot[1] = 3'($urandom);
        for (int x = 0; x < 2; x++) begin
            g_cyc[x] = -1; d_cyc[x] = -1; rv_cyc[x] = -1; got[x] = 0; done[x] = !go[x]; rc[x] = 0;
            got_data[x] = 'x; got_resp[x] = 'x;
        end
        arvalid = go;
        while (!(done[0] && done[1]) && cyc < 200) begin
            @(posedge clk); #1; cyc++;
            if (err_timeout) begin
                err_cnt++;
                if (err_cyc < 0) begin err_cyc = cyc; marv_at_err = m_arvalid; mrr_at_err = m_rready; end
            end
            for (int x = 0; x < 2; x++) begin
                if (arready[x]) begin
                    if (arvalid[x]) begin
                        arvalid[x] = 0; g_cyc[x] = cyc; gid_q.push_back(x); gout_q.push_back(grant_id);
                    end else stray++;
                end
                if (rvalid[x]) begin
                    if (done[x] || g_cyc[x] < 0) stray++;
                    else if (!got[x]) begin
                        got[x] = 1; rv_cyc[x] = cyc; got_data[x] = rdata[x]; got_resp[x] = rresp[x];
                    end else if (rdata[x] !== got_data[x] || rresp[x] !== got_resp[x]) unstable++;
                    if (rc[x] >= rdly) rready[x] = 1;
                    rc[x]++;
                end else if (got[x] && !done[x]) begin
                    done[x] = 1; d_cyc[x] = cyc; rready[x] = 0;
                end
            end
        end
        run_to = !(done[0] && done[1]);
        arvalid = '0; rready = '0;
    endtask

    task automatic do_reset();
        rst_n = 0; arvalid = '0; rready = '0;
        @(posedge clk); #1;
        rst_n = 1;
    endtask

    bit lg;  // model of the last-granted requester

    task automatic test_reset();
        rst_n = 0; arvalid = '0; rready = '0;
        repeat (2) @(posedge clk);
        #1;
        n_total++; if ({arready, rvalid} !== 4'b0) $display("FAIL rst_handshake: got %b required 0", {arready, rvalid}); else n_pass++;
        n_total++; if (rdata[0] !== 0 || rdata[1] !== 0) $display("FAIL rst_rdata: got %h %h required 0", rdata[0], rdata[1]); else n_pass++;
        n_total++; if (rresp[0] !== 0 || rresp[1] !== 0) $display("FAIL rst_rresp: got %b %b required 0", rresp[0], rresp[1]); else n_pass++;
        n_total++; if ({m_arvalid, m_rready, grant_id, busy, err_timeout} !== 5'b0)
            $display("FAIL rst_ctrl: got %b required 0", {m_arvalid, m_rready, grant_id, busy, err_timeout}); else n_pass++;
        n_total++; if (m_araddr !== 0 || m_arprot !== 0) $display("FAIL rst_maddr: got %h/%h required 0", m_araddr, m_arprot); else n_pass++;
        rst_n = 1;
        lg = 1;
    endtask

    task automatic test_single();
        ar_lat = 1; r_lat = 2; slv_resp = 2'b00;
        run_reqs(2'b01, 32'h10, 32'h0, 0);
        lg = 0;
        n_total++; if (run_to || g_cyc[0] !== 1) $display("FAIL single_arready_lat: got %0d required 1", g_cyc[0]); else n_pass++;
        n_total++; if (got_data[0] !== 32'h0050_0093) $display("FAIL single_rdata: got %h required 00500093", got_data[0]); else n_pass++;
        n_total++; if (got_resp[0] !== 2'b00) $display("FAIL single_rresp: got %b required 00", got_resp[0]); else n_pass++;
        n_total++; if (seen_addr.size() != 1 || seen_addr[0] !== 32'h10 || seen_prot[0] !== arprot[0])
            $display("FAIL single_m_addr: got %0d beats required 1 beat of 00000010 prot %b", seen_addr.size(), arprot[0]); else n_pass++;
        n_total++; if (gout_q.size() != 1 || gout_q[0] !== 1'b0) $display("FAIL single_grant_id: got %0d entries required one 0", gout_q.size()); else n_pass++;
        n_total++; if (stray != 0 || unstable != 0) $display("FAIL single_s1_quiet: got stray %0d unstable %0d required 0", stray, unstable); else n_pass++;
    endtask

    task automatic test_round_robin();
        logic [31:0] a [2];
        logic [1:0]  pat;
        int first, second, n;
        do_reset();
        lg = 1;
        for (int i = 0; i < 12; i++) begin
            pat = (i < 2) ? 2'b11 : (i < 4) ? 2'b10 : 2'($urandom_range(1, 3));
            a[0] = (i == 0) ? 32'h0 : ($urandom & 32'h0003_FFFC);
            a[1] = (i == 0) ? 32'h4 : ($urandom & 32'h0003_FFFC);
            ar_lat = $urandom_range(0, 3); r_lat = $urandom_range(0, 3);
            if (pat == 2'b11) begin first = int'(!lg); second = int'(lg); n = 2; lg = second[0]; end
            else begin first = (pat == 2'b10) ? 1 : 0; second = first; n = 1; lg = first[0]; end
            run_reqs(pat, a[0], a[1], $urandom_range(0, 2));
            n_total++; if (run_to || gid_q.size() != n || gid_q[0] != first)
                $display("FAIL rr_order[%0d]: got %0d grants first %0d required %0d grants first %0d",
                         i, gid_q.size(), (gid_q.size() > 0) ? gid_q[0] : -1, n, first);
            else n_pass++;
            if (n == 2) begin
                n_total++; if (g_cyc[second] != d_cyc[first] + 1)
                    $display("FAIL rr_gap[%0d]: got grant cycle %0d required %0d", i, g_cyc[second], d_cyc[first] + 1);
                else n_pass++;
            end
            for (int x = 0; x < 2; x++) if (pat[x]) begin
                n_total++; if (got_data[x] !== mem_word(a[x]) || got_resp[x] !== 2'b00)
                    $display("FAIL rr_data[%0d] s%0d: got %h/%b required %h/00", i, x, got_data[x], got_resp[x], mem_word(a[x]));
                else n_pass++;
            end
            n_total++; if (seen_addr.size() != n || seen_addr[0] !== a[first] || seen_prot[0] !== arprot[first])
                $display("FAIL rr_m_addr[%0d]: got %0d beats required %0d, first %h", i, seen_addr.size(), n, a[first]);
            else n_pass++;
            n_total++; if (stray != 0 || unstable != 0)
                $display("FAIL rr_quiet[%0d]: got stray %0d unstable %0d required 0", i, stray, unstable);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        int win, lose;
        ar_lat = 0; r_lat = 1;
        win = int'(!lg); lose = int'(lg); lg = lose[0];
        run_reqs(2'b11, 32'h100, 32'h200, 5);
        n_total++; if (run_to || gid_q.size() != 2 || gid_q[0] != win)
            $display("FAIL b2b_order: got first %0d required %0d", (gid_q.size() > 0) ? gid_q[0] : -1, win); else n_pass++;
        n_total++; if (unstable != 0) $display("FAIL b2b_hold_stable: got %0d changes required 0", unstable); else n_pass++;
        n_total++; if (d_cyc[win] - rv_cyc[win] != 6) $display("FAIL b2b_rvalid_len: got %0d required 6", d_cyc[win] - rv_cyc[win]); else n_pass++;
        n_total++; if (g_cyc[lose] != d_cyc[win] + 1) $display("FAIL b2b_loser_grant: got %0d required %0d", g_cyc[lose], d_cyc[win] + 1); else n_pass++;
    endtask

    task automatic test_timeout();
        int who;
        for (int mode = 0; mode < 2; mode++) begin
            hang_ar = (mode == 0); hang_r = (mode == 1); ar_lat = 1;
            who = $urandom_range(0, 1);
            run_reqs(who ? 2'b10 : 2'b01, 32'h40, 32'h80, 0);
            lg = who[0];
            n_total++; if (run_to || err_cyc != g_cyc[who] + TO - 1)
                $display("FAIL to_time[%0d]: got %0d required %0d", mode, err_cyc, g_cyc[who] + TO - 1); else n_pass++;
            n_total++; if (err_cnt != 1) $display("FAIL to_pulse[%0d]: got %0d required 1", mode, err_cnt); else n_pass++;
            n_total++; if (marv_at_err !== 1'b0 || mrr_at_err !== 1'b0)
                $display("FAIL to_m_drop[%0d]: got %b%b required 00", mode, marv_at_err, mrr_at_err); else n_pass++;
            n_total++; if (got_data[who] !== 32'h0 || got_resp[who] !== 2'b11)
                $display("FAIL to_decerr[%0d]: got %h/%b required 00000000/11", mode, got_data[who], got_resp[who]); else n_pass++;
        end
        hang_ar = 0; hang_r = 0;
    endtask

    task automatic test_reset_mid();
        int k = 0;
        logic [31:0] a1;
        ar_lat = 0; r_lat = 8;
        araddr[1] = 32'h300; arvalid[1] = 1;
        while (!m_rready && k < 20) begin
            @(posedge clk); #1; k++;
            if (arready[1]) arvalid[1] = 0;
        end
        n_total++; if (m_rready !== 1'b1) $display("FAIL mid_reach_rwait: got %b required 1", m_rready); else n_pass++;
        rst_n = 0; arvalid = '0;
        @(posedge clk); #1;
        n_total++; if ({arready, rvalid} !== 4'b0) $display("FAIL mid_rst_handshake: got %b required 0", {arready, rvalid}); else n_pass++;
        n_total++; if ({m_arvalid, m_rready, grant_id, busy, err_timeout} !== 5'b0)
            $display("FAIL mid_rst_ctrl: got %b required 0", {m_arvalid, m_rready, grant_id, busy, err_timeout}); else n_pass++;
        n_total++; if (m_araddr !== 0 || rdata[1] !== 0) $display("FAIL mid_rst_data: got %h/%h required 0", m_araddr, rdata[1]); else n_pass++;
        rst_n = 1; lg = 1; r_lat = 1;
        a1 = $urandom & 32'h0000_FFFC;
        run_reqs(2'b10, 32'h0, a1, 1);
        lg = 1;
        n_total++; if (run_to || g_cyc[1] != 1) $display("FAIL mid_after_lat: got %0d required 1", g_cyc[1]); else n_pass++;
        n_total++; if (got_data[1] !== mem_word(a1) || got_resp[1] !== 2'b00)
            $display("FAIL mid_after_data: got %h/%b required %h/00", got_data[1], got_resp[1], mem_word(a1)); else n_pass++;
    endtask

    task automatic test_slverr();
        logic [31:0] a1;
        ar_lat = 1; r_lat = 1; slv_resp = 2'b10;
        a1 = $urandom & 32'h0000_FFFC;
        run_reqs(2'b10, 32'h0, a1, 0);
        lg = 1;
        n_total++; if (run_to || got_resp[1] !== 2'b10) $display("FAIL slverr_resp: got %b required 10", got_resp[1]); else n_pass++;
        n_total++; if (got_data[1] !== mem_word(a1)) $display("FAIL slverr_data: got %h required %h", got_data[1], mem_word(a1)); else n_pass++;
        n_total++; if (err_cnt != 0) $display("FAIL slverr_no_timeout: got %0d pulses required 0", err_cnt); else n_pass++;
        slv_resp = 2'b00;
    endtask

    initial begin
        araddr[0] = '0; araddr[1] = '0; arprot[0] = '0; arprot[1] = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_back_to_back();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_slverr();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_time_limit: simulation did not finish, passed %0d of %0d", n_pass, n_total);
        $fatal(1);
    end

endmodule
